boron_round_key_store: RTL and testbench

Key-expansion and round-key buffer for the Boron decryption path. Accepts an 80-bit master key, runs the 25-step Boron key schedule iteratively (one step per cycle), and stores all 26 64-bit round keys. It then streams them to the decryption round datapath in reverse order (K25 first) over a valid/ready handshake. It sits between the key-load interface and the round datapath.

---
 rtl/boron_round_key_store_pkg.sv | 41 ++++
 rtl/boron_round_key_store_key_step.sv | 24 ++
 rtl/boron_round_key_store.sv | 148 ++++++++++++++
 tb/tb_boron_round_key_store.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/boron_round_key_store_pkg.sv
// Shared definitions for the Boron round-key store.
// Holds key/round-key geometry, key-schedule constants, the 4-bit S-box
// lookup and the controller state encoding.
package boron_round_key_store_pkg;

  localparam int unsigned KEY_BITS = 80;
  localparam int unsigned RK_BITS  = 64;
  localparam int unsigned NUM_RK   = 26;
  localparam int unsigned ROT_AMT  = 13;
  localparam logic [4:0]  LAST_RK  = 5'd25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_SERVE
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;
      4'h1: y = 4'h4;
      4'h2: y = 4'hB;
      4'h3: y = 4'h1;
      4'h4: y = 4'h7;
      4'h5: y = 4'h9;
      4'h6: y = 4'hC;
      4'h7: y = 4'hA;
      4'h8: y = 4'hD;
      4'h9: y = 4'h2;
      4'hA: y = 4'h0;
      4'hB: y = 4'hF;
      4'hC: y = 4'h8;
      4'hD: y = 4'h5;
      4'hE: y = 4'h3;
      default: y = 4'h6;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/boron_round_key_store_key_step.sv
// boron_key_step: one combinational step of the Boron key schedule.
// Ports:
//   key - current 80-bit working key
//   rnd - 5-bit round counter mixed into bits [63:59]
//   nxt - next working key: rotl13, counter XOR, S-box on low nibble
module boron_key_step
  import boron_round_key_store_pkg::*;
(
  input  logic [KEY_BITS-1:0] key,
  input  logic [4:0]          rnd,
  output logic [KEY_BITS-1:0] nxt
);

  logic [KEY_BITS-1:0] rot;

  assign rot = {key[KEY_BITS-ROT_AMT-1:0], key[KEY_BITS-1:KEY_BITS-ROT_AMT]};

  always_comb begin
    nxt        = rot;
    nxt[63:59] = rot[63:59] ^ rnd;
    nxt[3:0]   = sbox(rot[3:0]);
  end

endmodule

// File: rtl/boron_round_key_store.sv
// boron_round_key_store: expands an 80-bit master key into 26 round keys
// (one schedule step per cycle) and streams them to the round datapath.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   key_valid/key_ready/key_in - master key load handshake (ready in IDLE)
//   busy               - expansion in progress
//   rk_dir             - 0 reverse (K25..K0), 1 forward (K0..K25)
//   rk_valid/rk_ready  - round-key stream handshake
//   rk_data/rk_idx/rk_last - current key, its index, end-of-sequence flag
// Build option: BORON_RK_FWD_EN enables forward streaming via rk_dir;
// without it rk_dir is ignored and keys always stream in reverse.
module boron_round_key_store #(
  parameter int unsigned KEY_BITS = boron_round_key_store_pkg::KEY_BITS,
  parameter int unsigned RK_BITS  = boron_round_key_store_pkg::RK_BITS,
  parameter int unsigned NUM_RK   = boron_round_key_store_pkg::NUM_RK
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  input  logic                rk_dir,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [RK_BITS-1:0]  rk_data,
  output logic [4:0]          rk_idx,
  output logic                rk_last
);

  import boron_round_key_store_pkg::*;

  state_t              state, state_nxt;
  logic [KEY_BITS-1:0] kreg;
  logic [KEY_BITS-1:0] kreg_nxt;
  logic [4:0]          cnt;
  logic [4:0]          ptr;
  logic [RK_BITS-1:0]  rk [NUM_RK];
  logic                fwd;
  logic                at_end;
  logic                key_acc;
  logic                rk_acc;

  boron_key_step u_step (
    .key (kreg),
    .rnd (cnt),
    .nxt (kreg_nxt)
  );

`ifdef BORON_RK_FWD_EN
  logic dir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= 1'b0;
    end else if (key_acc) begin
      dir_q <= rk_dir;
    end
  end

  assign fwd = dir_q;
`else
  logic unused_rk_dir;
  assign unused_rk_dir = rk_dir;
  assign fwd = 1'b0;
`endif

  assign key_acc = (state == ST_IDLE) && key_valid;
  assign rk_acc  = (state == ST_SERVE) && rk_ready;
  assign at_end  = fwd ? (ptr == LAST_RK) : (ptr == 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (key_valid) state_nxt = ST_EXPAND;
      ST_EXPAND: if (cnt == LAST_RK) state_nxt = ST_SERVE;
      ST_SERVE:  if (rk_ready && at_end) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kreg <= '0;
      cnt  <= '0;
      ptr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_valid) begin
            kreg <= key_in;
            cnt  <= 5'd1;
          end
        end
        ST_EXPAND: begin
          kreg <= kreg_nxt;
          if (cnt == LAST_RK) begin
            cnt <= '0;
`ifdef BORON_RK_FWD_EN
            ptr <= dir_q ? 5'd0 : LAST_RK;
`else
            ptr <= LAST_RK;
`endif
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        ST_SERVE: begin
          if (rk_acc && !at_end) begin
`ifdef BORON_RK_FWD_EN
            ptr <= dir_q ? ptr + 5'd1 : ptr - 5'd1;
`else
            ptr <= ptr - 5'd1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Key storage is deliberately not reset; stale contents are unreachable
  // because SERVE is only entered after a full re-expansion.
  always_ff @(posedge clk) begin
    if (key_acc) begin
      rk[0] <= key_in[RK_BITS-1:0];
    end
    if (state == ST_EXPAND) begin
      rk[cnt] <= kreg_nxt[RK_BITS-1:0];
    end
  end

  assign key_ready = (state == ST_IDLE);
  assign busy      = (state == ST_EXPAND);
  assign rk_valid  = (state == ST_SERVE);
  assign rk_data   = rk_valid ? rk[ptr] : '0;
  assign rk_idx    = rk_valid ? ptr : '0;
  assign rk_last   = rk_valid && at_end;

endmodule

// File: tb/tb_boron_round_key_store.sv
module tb_boron_round_key_store;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic        key_ready;
  logic [79:0] key_in;
  logic        busy;
  logic        rk_dir;
  logic        rk_valid;
  logic        rk_ready;
  logic [63:0] rk_data;
  logic [4:0]  rk_idx;
  logic        rk_last;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

`ifdef BORON_RK_FWD_EN
  localparam bit FWD_BUILT = 1'b1;
`else
  localparam bit FWD_BUILT = 1'b0;
`endif

  boron_round_key_store #(
    .KEY_BITS (80),
    .RK_BITS  (64),
    .NUM_RK   (26)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .busy      (busy),
    .rk_dir    (rk_dir),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_data   (rk_data),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'hE4B179CA_D20F8536;
    return tbl[63 - 4*x -: 4];
  endfunction

  function automatic logic [79:0] ref_step(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] r;
    r = (k << 13) | (k >> 67);
    r[63:59] = r[63:59] ^ c;
    r[3:0]   = ref_sbox(r[3:0]);
    return r;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_key_ready"}, 80'(key_ready), 80'd1);
    check({pfx, "_busy"},      80'(busy),      80'd0);
    check({pfx, "_rk_valid"},  80'(rk_valid),  80'd0);
    check({pfx, "_rk_data"},   80'(rk_data),   80'd0);
    check({pfx, "_rk_idx"},    80'(rk_idx),    80'd0);
    check({pfx, "_rk_last"},   80'(rk_last),   80'd0);
  endtask

  // Load one key, follow expansion, then consume all 26 round keys.
  task automatic run_key(input logic [79:0] key, input logic dir, input bit bp);
    logic [63:0] exp_rk [26];
    logic [79:0] k;
    bit          fwd;
    int unsigned n;
    int unsigned busy_cyc;
    int unsigned e;
    int unsigned cyc;
    int unsigned idx;
    bit          ready;

    k = key;
    exp_rk[0] = k[63:0];
    for (int i = 1; i < 26; i++) begin
      k = ref_step(k, 5'(i));
      exp_rk[i] = k[63:0];
    end
    fwd = FWD_BUILT && dir;

    key_in    = key;
    rk_dir    = dir;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    rk_dir    = ~dir;

    n = 0;
    busy_cyc = 0;
    while (!rk_valid && n < 100) begin
      if (busy) busy_cyc++;
      if (n == 4) check("expand_key_ready", 80'(key_ready), 80'd0);
      key_valid = (n == 4);
      key_in    = ~key;
      n++;
      @(negedge clk);
    end
    key_valid = 1'b0;
    check("busy_cycles", 80'(busy_cyc), 80'd25);
    check("valid_latency", 80'(n), 80'd25);

    e = 0;
    cyc = 0;
    while (e < 26 && cyc < 300) begin
      idx = fwd ? e : 25 - e;
      check("rk_valid", 80'(rk_valid), 80'd1);
      check("rk_idx",   80'(rk_idx),   80'(idx));
      check("rk_data",  80'(rk_data),  80'(exp_rk[idx]));
      check("rk_last",  80'(rk_last),  80'(e == 25));
      check("serve_key_ready", 80'(key_ready), 80'd0);
      if (key == 80'd0 && idx == 1)
        check("k1_const", 80'(rk_data), 80'h0800_0000_0000_000E);
      ready     = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready  = ready;
      key_valid = (e == 10);
      cyc++;
      @(negedge clk);
      if (ready) e++;
    end
    rk_ready  = 1'b0;
    key_valid = 1'b0;
    check("serve_count", 80'(e), 80'd26);
    if (!bp) check("serve_cycles", 80'(cyc), 80'd26);
    check("done_key_ready", 80'(key_ready), 80'd1);
    check("done_rk_valid",  80'(rk_valid),  80'd0);
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    rk_dir    = 1'b0;
    rk_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    run_key(80'd0, 1'b0, 1'b0);
    run_key(80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_key(80'h0123_4567_89AB_CDEF_1357, 1'b0, 1'b1);

    // Abort mid-expansion, then a clean run must still be correct.
    key_in    = 80'hDEAD_BEEF_0000_1111_2222;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort_busy", 80'(busy), 80'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    @(negedge clk);
    run_key(80'hA5A5_5A5A_0F0F_F0F0_3C3C, 1'b0, 1'b0);

    // Forward request: honoured only in the forward-capable build.
    run_key(80'h1111_2222_3333_4444_5555, 1'b1, 1'b0);
    run_key(80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
